// File: rtl/tx_frame_queue_pkg.sv
// rtl/tx_frame_queue_pkg.sv - shared FSM encoding, status bit map and command priority for tx_frame_queue
package tx_frame_queue_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam int STAT_FIFO_EMPTY = 0;
    localparam int STAT_BUF_FULL   = 1;
    localparam int STAT_FIFO_FULL  = 2;
    localparam int STAT_BUSY       = 3;
    localparam int STAT_OVERFLOW   = 8;
    localparam int STAT_FRM_OVF    = 9;
    localparam int STAT_EMPTY_FRM  = 10;
    localparam int STAT_CONFLICT   = 11;

    // Bit positions in the command request vector; a higher bit wins.
    localparam int REQ_DATA_WE    = 0;
    localparam int REQ_PUSH_IDX   = 1;
    localparam int REQ_PUSH_FRAME = 2;
    localparam int REQ_POP_IDX    = 3;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_POP_IDX,
        CMD_PUSH_FRAME,
        CMD_PUSH_IDX,
        CMD_WRITE
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic [3:0] req);
        if (req[REQ_POP_IDX])    return CMD_POP_IDX;
        if (req[REQ_PUSH_FRAME]) return CMD_PUSH_FRAME;
        if (req[REQ_PUSH_IDX])   return CMD_PUSH_IDX;
        if (req[REQ_DATA_WE])    return CMD_WRITE;
        return CMD_NONE;
    endfunction

    function automatic logic cmd_conflict(input logic [3:0] req);
        return (req & (req - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/tx_len_fifo.sv
// rtl/tx_len_fifo.sv - synchronous FIFO holding committed frame lengths
module tx_len_fifo
#(
    parameter int DATA_W  = 9,
    parameter int DEPTH_W = 3
)
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clr_n,
    input  logic                i_wr_en,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_rd_en,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [DEPTH_W:0]    o_count
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_W)-1];
    logic [DEPTH_W:0]  wr_ptr;
    logic [DEPTH_W:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign o_count   = wr_ptr - rd_ptr;
    assign o_full    = o_count[DEPTH_W];
    assign o_empty   = (o_count == '0);
    assign do_wr     = i_wr_en && !o_full;
    assign do_rd     = i_rd_en && !o_empty;
    assign o_rd_data = mem[rd_ptr[DEPTH_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr[DEPTH_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!i_clr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_queue.sv
// rtl/tx_frame_queue.sv - byte buffer with checkpointed open frame and framed output stream
module tx_frame_queue
    import tx_frame_queue_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int FRM_W  = 3
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_soft_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_data_we,
    input  logic        i_push_write_index,
    input  logic        i_pop_write_index,
    input  logic        i_push_frame,
    output logic [15:0] o_data_size,
    output logic [7:0]  o_frames_count,
    output logic [15:0] o_status,
    output logic [7:0]  o_out_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_out_last
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [0:DEPTH-1];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  chk_ptr;
    logic [PTR_W-1:0]  cur_len;
    logic [PTR_W-1:0]  chk_len;
    logic [PTR_W-1:0]  remaining;
    logic [PTR_W-1:0]  used;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [1:0]        rd_state;

    logic              sticky_ovf;
    logic              sticky_frm_ovf;
    logic              sticky_empty;
    logic              sticky_conflict;

    logic [3:0]        cmd_req;
    cmd_e              cmd;
    logic              conflict;
    logic              buf_full;
    logic              do_write;
    logic              do_commit;
    logic              handshake;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W-1:0]  fifo_head;
    logic [FRM_W:0]    fifo_count;

    always_comb begin
        cmd_req                 = '0;
        cmd_req[REQ_DATA_WE]    = i_data_we;
        cmd_req[REQ_PUSH_IDX]   = i_push_write_index;
        cmd_req[REQ_PUSH_FRAME] = i_push_frame;
        cmd_req[REQ_POP_IDX]    = i_pop_write_index;
    end

    assign cmd         = decode_cmd(cmd_req);
    assign conflict    = cmd_conflict(cmd_req);
    // wr_ptr never runs more than DEPTH ahead of rd_ptr, so the MSB of the distance means full.
    assign used        = wr_ptr - rd_ptr;
    assign buf_full    = used[ADDR_W];
    assign do_write    = i_soft_rst_n && (cmd == CMD_WRITE) && !buf_full;
    assign do_commit   = i_soft_rst_n && (cmd == CMD_PUSH_FRAME) && (cur_len != '0) && !fifo_full;
    assign handshake   = o_out_valid && i_out_ready;
    assign fifo_pop    = (rd_state == ST_STREAM) && handshake && o_out_last;
    assign rd_ptr_next = rd_ptr + 1'b1;

    tx_len_fifo #(
        .DATA_W  (PTR_W),
        .DEPTH_W (FRM_W)
    ) u_len_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr_n   (i_soft_rst_n),
        .i_wr_en   (do_commit),
        .i_wr_data (cur_len),
        .i_rd_en   (fifo_pop),
        .o_rd_data (fifo_head),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr          <= '0;
            chk_ptr         <= '0;
            cur_len         <= '0;
            chk_len         <= '0;
            sticky_ovf      <= 1'b0;
            sticky_frm_ovf  <= 1'b0;
            sticky_empty    <= 1'b0;
            sticky_conflict <= 1'b0;
        end else if (!i_soft_rst_n) begin
            wr_ptr          <= '0;
            chk_ptr         <= '0;
            cur_len         <= '0;
            chk_len         <= '0;
            sticky_ovf      <= 1'b0;
            sticky_frm_ovf  <= 1'b0;
            sticky_empty    <= 1'b0;
            sticky_conflict <= 1'b0;
        end else begin
            if (conflict) begin
                sticky_conflict <= 1'b1;
            end
            case (cmd)
                CMD_POP_IDX: begin
                    wr_ptr  <= chk_ptr;
                    cur_len <= chk_len;
                end
                CMD_PUSH_FRAME: begin
                    if (cur_len == '0) begin
                        sticky_empty <= 1'b1;
                    end else if (fifo_full) begin
                        sticky_frm_ovf <= 1'b1;
                    end else begin
                        chk_ptr <= wr_ptr;
                        cur_len <= '0;
                        chk_len <= '0;
                    end
                end
                CMD_PUSH_IDX: begin
                    chk_ptr <= wr_ptr;
                    chk_len <= cur_len;
                end
                CMD_WRITE: begin
                    if (buf_full) begin
                        sticky_ovf <= 1'b1;
                    end else begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        cur_len <= cur_len + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_state    <= ST_IDLE;
            rd_ptr      <= '0;
            remaining   <= '0;
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
        end else if (!i_soft_rst_n) begin
            rd_state    <= ST_IDLE;
            rd_ptr      <= '0;
            remaining   <= '0;
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
        end else begin
            case (rd_state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        remaining <= fifo_head;
                        rd_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    o_out_data  <= mem[rd_ptr[ADDR_W-1:0]];
                    o_out_valid <= 1'b1;
                    o_out_last  <= (remaining == PTR_W'(1));
                    rd_state    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (handshake) begin
                        rd_ptr    <= rd_ptr_next;
                        remaining <= remaining - 1'b1;
                        if (o_out_last) begin
                            o_out_valid <= 1'b0;
                            o_out_last  <= 1'b0;
                            rd_state    <= ST_IDLE;
                        end else begin
                            // Prefetch the following byte so the stream has no bubbles.
                            o_out_data <= mem[rd_ptr_next[ADDR_W-1:0]];
                            o_out_last <= (remaining == PTR_W'(2));
                        end
                    end
                end
                default: begin
                    rd_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data_size    = 16'(used);
    assign o_frames_count = 8'(fifo_count);

    always_comb begin
        o_status                  = '0;
        o_status[STAT_FIFO_EMPTY] = fifo_empty;
        o_status[STAT_BUF_FULL]   = buf_full;
        o_status[STAT_FIFO_FULL]  = fifo_full;
        o_status[STAT_BUSY]       = (rd_state != ST_IDLE);
        o_status[STAT_OVERFLOW]   = sticky_ovf;
        o_status[STAT_FRM_OVF]    = sticky_frm_ovf;
        o_status[STAT_EMPTY_FRM]  = sticky_empty;
        o_status[STAT_CONFLICT]   = sticky_conflict;
    end

endmodule

// File: doc/tx_frame_queue.md
TX_FRAME_QUEUE -- requirements
Module: tx_frame_queue

Interface
REQ-001 Parameter ADDR_W, default 8, byte buffer depth = 2^ADDR_W.
REQ-002 Parameter FRM_W, default 3, frame-length queue depth = 2^FRM_W.
REQ-003 i_clk  in  1  clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_soft_rst_n  in  1  synchronous clear, active-low (driven by the host control register bit).
REQ-006 i_data  in  8  byte to append to the open frame.
REQ-007 i_data_we  in  1  append strobe, one byte per cycle high.
REQ-008 i_push_write_index  in  1  save checkpoint of the open frame.
REQ-009 i_pop_write_index  in  1  roll the open frame back to the checkpoint.
REQ-010 i_push_frame  in  1  commit the open frame to the output queue.
REQ-011 o_data_size  out  16  bytes held (committed + open), zero-extended.
REQ-012 o_frames_count  out  8  committed frames not yet fully streamed, zero-extended.
REQ-013 o_status  out  16  flag word per REQ-030.
REQ-014 o_out_data  out  8  streamed byte.
REQ-015 o_out_valid  out  1  o_out_data valid.
REQ-016 i_out_ready  in  1  consumer accepts byte when high with o_out_valid.
REQ-017 o_out_last  out  1  current byte is the final byte of its frame.

Function
REQ-018 State: wr_ptr, rd_ptr, cmt_ptr (ADDR_W+1 bits); cur_len, chk_len (ADDR_W+1 bits); chk_ptr; frame-length FIFO of ADDR_W+1-bit entries.
REQ-019 Command priority within a cycle: pop_write_index > push_frame > push_write_index > data_we; lower-priority asserted commands are ignored and set the conflict flag.
REQ-020 data_we with used < 2^ADDR_W: mem[wr_ptr] <= i_data, wr_ptr++, cur_len++; at used == 2^ADDR_W the byte is dropped and the overflow flag is set.
REQ-021 push_write_index: chk_ptr <= wr_ptr, chk_len <= cur_len.
REQ-022 pop_write_index: wr_ptr <= chk_ptr, cur_len <= chk_len; committed data and streaming unaffected.
REQ-023 push_frame with cur_len == 0: ignored, empty-frame flag set.
REQ-024 push_frame with frame FIFO full: ignored, frame-overflow flag set, open frame kept intact.
REQ-025 Otherwise push_frame enqueues cur_len, cmt_ptr <= wr_ptr, chk_ptr <= wr_ptr, cur_len <= 0, chk_len <= 0.
REQ-026 Read FSM states IDLE, FETCH, STREAM; IDLE->FETCH when frame FIFO non-empty, loading remaining count from FIFO head.
REQ-027 FETCH: register mem[rd_ptr] into o_out_data, o_out_valid <= 1, o_out_last <= (remaining == 1), ->STREAM; first byte valid 2 cycles after the frame becomes available.
REQ-028 STREAM: o_out_data/o_out_last held stable while i_out_ready low; on handshake rd_ptr++, remaining--; if not last, next byte presented the following cycle (no bubbles); if last, pop frame FIFO, o_out_valid <= 0, ->IDLE.
REQ-029 used = wr_ptr - rd_ptr (ADDR_W+1-bit modular); bytes free on the cycle after their handshake; o_frames_count decrements on the last-byte handshake.
REQ-030 o_status: [0] frame FIFO empty, [1] byte buffer full, [2] frame FIFO full, [3] FSM not IDLE, [8] overflow, [9] frame-overflow, [10] empty-frame, [11] conflict (bits 8-11 sticky); all other bits 0.
REQ-031 Simultaneous write and last-byte handshake on a full buffer: the write is dropped (fullness evaluated before the handshake frees space).

Reset
REQ-032 i_rst_n low: all pointers, counters, FIFO, sticky flags and FSM (IDLE) cleared; o_out_valid = 0, o_out_last = 0, o_out_data = 0, o_data_size = 0, o_frames_count = 0, o_status = 0x0001.
REQ-033 i_soft_rst_n low for one cycle: same state as REQ-032 on the next edge, including mid-frame abort of streaming; buffer contents need not be cleared.

Structure
REQ-034 Shared package: FSM state encoding, o_status bit positions, command priority constants.
REQ-035 One sub-module, tx_len_fifo: a synchronous frame-length FIFO with full and empty outputs and a count output; the byte memory is inline.

Verification
REQ-036 Write 0x11,0x22,0x33, push_frame, ready=1 -> out 0x11,0x22,0x33 on consecutive cycles, last on 0x33, frames_count 1->0.
REQ-037 Write 0xA0, push_write_index, write 0xB0,0xB1, pop_write_index, write 0xC0, push_frame -> stream 0xA0,0xC0; data_size 2 before streaming.
REQ-038 Fill 256 bytes, write 0xFF -> dropped, status[8]=1, [1]=1, data_size 256.
REQ-039 Commit 8 one-byte frames with ready=0, 9th push_frame -> ignored, status[9]=1, [2]=1, frames_count 8.
REQ-040 Toggle ready 1/0 mid-frame -> data held stable while ready low; no byte lost or duplicated.
REQ-041 Assert i_rst_n low mid-stream -> o_out_valid 0 immediately, o_status 0x0001, o_data_size 0.
